// File: rtl/prog_loader_pkg.sv
// Shared types and widths for the program loader.
package prog_loader_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned WORD_W    = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StRead,
    StResult,
    StError
  } state_e;

endpackage

// File: rtl/prog_loader_ctr.sv
// Program word-address counter and cpu run-cycle counter, each with clear/enable/terminal count.
module prog_loader_ctr #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned MAX_CYCLES = 100
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              addr_clr_i,
  input  logic              addr_en_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              addr_tc_o,
  input  logic              cnt_clr_i,
  input  logic              cnt_en_i,
  output logic              cnt_tc_o
);

  localparam int unsigned CntW = $clog2(MAX_CYCLES + 1);

  logic [ADDR_W-1:0] addr_q;
  logic [CntW-1:0]   cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q <= '0;
    end else if (addr_clr_i) begin
      addr_q <= '0;
    end else if (addr_en_i) begin
      addr_q <= addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (cnt_clr_i) begin
      cnt_q <= '0;
    end else if (cnt_en_i) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign addr_o    = addr_q;
  assign addr_tc_o = (addr_q == '1);
  // Terminal one cycle early so the run lasts exactly MAX_CYCLES cycles.
  assign cnt_tc_o  = (cnt_q == CntW'(MAX_CYCLES - 1));

endmodule

// File: rtl/prog_loader.sv
// Host-side program loader: streams words into cpu memory, runs the cpu, reads back a result.
// Optional PROG_LOADER_CHECKSUM_EN adds a load_sum output (mod-2^32 sum of the loaded words).
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned RES_REG    = 2,
  parameter int unsigned MAX_CYCLES = 100
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_W-1:0]    in_data,
  input  logic                 in_last,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [WORD_W-1:0]    mem_wdata,
  output logic                 cpu_run,
  input  logic                 halt,
  output logic [REG_IDX_W-1:0] dbg_raddr,
  input  logic [WORD_W-1:0]    dbg_rdata,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WORD_W-1:0]    res_data,
  output logic                 res_tmo,
`ifdef PROG_LOADER_CHECKSUM_EN
  output logic [WORD_W-1:0]    load_sum,
`endif
  output logic                 load_err
);

  localparam logic [REG_IDX_W-1:0] ResIdx = REG_IDX_W'(RES_REG);

  state_e                 state_q;
  logic                   run_q;
  logic [REG_IDX_W-1:0]   raddr_q;
  logic                   valid_q;
  logic [WORD_W-1:0]      data_q;
  logic                   tmo_q;
  logic                   err_q;

  logic                   loading;
  logic                   xfer;
  logic                   res_hs;
  logic [ADDR_W-1:0]      addr;
  logic                   addr_tc;
  logic                   cnt_tc;

  // Gating with reset_n keeps every output low while reset is held.
  assign loading = reset_n && ((state_q == StIdle) || (state_q == StLoad));
  assign xfer    = in_valid && loading;
  assign res_hs  = (state_q == StResult) && res_ready;

  prog_loader_ctr #(
    .ADDR_W     (ADDR_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_ctr (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .addr_clr_i (res_hs),
    .addr_en_i  (xfer),
    .addr_o     (addr),
    .addr_tc_o  (addr_tc),
    .cnt_clr_i  (res_hs),
    .cnt_en_i   (state_q == StRun),
    .cnt_tc_o   (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      run_q   <= 1'b0;
      raddr_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      tmo_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StLoad: begin
          if (xfer) begin
            if (in_last) begin
              state_q <= StRun;
              run_q   <= 1'b1;
            end else if (addr_tc) begin
              state_q <= StError;
              err_q   <= 1'b1;
            end else begin
              state_q <= StLoad;
            end
          end
        end
        StRun: begin
          // Halt takes precedence over timeout when both land in the same cycle.
          if (halt || cnt_tc) begin
            state_q <= StRead;
            run_q   <= 1'b0;
            tmo_q   <= !halt;
            raddr_q <= ResIdx;
          end
        end
        StRead: begin
          data_q  <= dbg_rdata;
          valid_q <= 1'b1;
          raddr_q <= '0;
          state_q <= StResult;
        end
        StResult: begin
          if (res_ready) begin
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
            data_q  <= '0;
            state_q <= StIdle;
          end
        end
        StError: begin
          state_q <= StError;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum_q;

  // First word of a load restarts the sum; frozen whenever no word is accepted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else if (xfer) begin
      sum_q <= (state_q == StIdle) ? in_data : (sum_q + in_data);
    end
  end

  assign load_sum = sum_q;
`endif

  assign in_ready  = loading;
  assign mem_we    = xfer;
  assign mem_addr  = xfer ? addr : '0;
  assign mem_wdata = xfer ? in_data : '0;
  assign cpu_run   = run_q;
  assign dbg_raddr = raddr_q;
  assign res_valid = valid_q;
  assign res_data  = data_q;
  assign res_tmo   = tmo_q;
  assign load_err  = err_q;

endmodule
